// File: rtl/abr_params_pkg.sv
// ML-KEM arithmetic constants shared by the masked datapath blocks.
package abr_params_pkg;

    localparam int MLKEM_Q       = 3329;
    localparam int MLKEM_Q_WIDTH = 12;

endpackage

// File: rtl/ntt_defines_pkg.sv
// Fixed pipeline latencies of the masked NTT arithmetic stages.
package ntt_defines_pkg;

    localparam int MASKED_MULT_LATENCY    = 2;
    localparam int MASKED_BARRETT_LATENCY = 6;

endpackage

// File: rtl/masked_share_mult_core.sv
// Two-stage arithmetic-share multiplier.
// Stage 1 holds the same-share products and the cross products. Each cross
// product is blinded with fresh randomness before it reaches a register.
// Stage 2 combines them into two output shares. Stage 2 removes the blinding
// by subtracting the randomness that was used for the other output share.
module masked_share_mult_core
    import abr_params_pkg::*;
#(
    parameter int MASKED_REG_SIZE = 2*MLKEM_Q_WIDTH
)(
    input  logic                             clk,
    input  logic                             clr_i,
    input  logic [1:0][MASKED_REG_SIZE-1:0]  u_i,
    input  logic [1:0][MASKED_REG_SIZE-1:0]  v_i,
    input  logic [MASKED_REG_SIZE-1:0]       rnd0_i,
    input  logic [MASKED_REG_SIZE-1:0]       rnd1_i,
    output logic [1:0][MASKED_REG_SIZE-1:0]  x_o
);

    logic [MASKED_REG_SIZE-1:0] p00_d, p11_d, c01_d, c10_d;
    logic [MASKED_REG_SIZE-1:0] p00_q, p11_q, c01_q, c10_q;
    logic [MASKED_REG_SIZE-1:0] rnd0_q, rnd1_q;
    logic [1:0][MASKED_REG_SIZE-1:0] x_d, x_q;

    // Stage-1 products, truncated to the share width. Each cross term is added
    // to its randomness in the same expression, so its raw value never reaches
    // a register.
    always_comb begin
        p00_d = u_i[0] * v_i[0];
        p11_d = u_i[1] * v_i[1];
        c01_d = u_i[0] * v_i[1] + rnd0_i;
        c10_d = u_i[1] * v_i[0] + rnd1_i;
    end

    // Stage-2 share recombination. Share 0 absorbs rnd0 and subtracts rnd1.
    // Share 1 absorbs rnd1 and subtracts rnd0. The sum of the shares is therefore u*v.
    always_comb begin
        x_d[0] = p00_q + c01_q - rnd1_q;
        x_d[1] = p11_q + c10_q - rnd0_q;
    end

    // Pipeline registers for both stages. They are free-running with no enable.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            p00_q  <= '0;
            p11_q  <= '0;
            c01_q  <= '0;
            c10_q  <= '0;
            rnd0_q <= '0;
            rnd1_q <= '0;
            x_q    <= '0;
        end else begin
            p00_q  <= p00_d;
            p11_q  <= p11_d;
            c01_q  <= c01_d;
            c10_q  <= c10_d;
            rnd0_q <= rnd0_i;
            rnd1_q <= rnd1_i;
            x_q    <= x_d;
        end
    end

    assign x_o = x_q;

endmodule

// File: rtl/masked_mult_reduce_feeder.sv
// Feeder for the masked Barrett reduction stage. It wraps the share multiplier
// with a valid/tag delay line that spans both the multiply latency and the
// downstream reduction latency. It also contains a batch counter and a busy flag.
module masked_mult_reduce_feeder
    import abr_params_pkg::*;
    import ntt_defines_pkg::*;
#(
    parameter int MASKED_REG_SIZE = 2*MLKEM_Q_WIDTH,
    parameter int TAG_W           = 8,
    parameter int RED_LATENCY     = MASKED_BARRETT_LATENCY,
    parameter int BATCH           = 256
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             zeroize,
    input  logic                             in_valid,
    input  logic [TAG_W-1:0]                 in_tag,
    input  logic [1:0][MASKED_REG_SIZE-1:0]  u,
    input  logic [1:0][MASKED_REG_SIZE-1:0]  v,
    input  logic [MASKED_REG_SIZE-1:0]       rnd0_24bit,
    input  logic [MASKED_REG_SIZE-1:0]       rnd1_24bit,
    output logic [1:0][MASKED_REG_SIZE-1:0]  x,
    output logic                             x_valid,
    output logic                             red_valid,
    output logic [TAG_W-1:0]                 red_tag,
    output logic                             batch_done,
    output logic                             busy
);

    localparam int DEPTH = MASKED_MULT_LATENCY + RED_LATENCY;
    localparam int CNT_W = $clog2(BATCH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BATCH - 1);

    logic clr;
    assign clr = rst | zeroize;

    masked_share_mult_core #(
        .MASKED_REG_SIZE (MASKED_REG_SIZE)
    ) u_core (
        .clk    (clk),
        .clr_i  (clr),
        .u_i    (u),
        .v_i    (v),
        .rnd0_i (rnd0_24bit),
        .rnd1_i (rnd1_24bit),
        .x_o    (x)
    );

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The tag is zeroed on entry when in_valid is low. Because every stage
    // carries the masked tag, red_tag is 0 whenever red_valid is 0.
    assign valid_d = {valid_q[DEPTH-2:0], in_valid};
    assign tag_d[0] = in_valid ? in_tag : '0;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_tag_shift
            assign tag_d[gi] = tag_q[gi-1];
        end
    endgenerate

    // Sideband delay line. A clear drops every in-flight entry and also drops
    // any input presented in the same cycle as the clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= tag_d[i];
        end
    end

    // Batch counter. It advances on each emerging result and wraps after the last result of a batch.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_q[DEPTH-1]) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Batch counter register.
    always_ff @(posedge clk) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign x_valid    = valid_q[MASKED_MULT_LATENCY-1];
    assign red_valid  = valid_q[DEPTH-1];
    assign red_tag    = tag_q[DEPTH-1];
    assign batch_done = valid_q[DEPTH-1] && (cnt_q == CNT_LAST);
    assign busy       = |valid_q;

endmodule

// File: tb/tb_masked_mult_reduce_feeder.sv
// Scoreboard bench for masked_mult_reduce_feeder: stimulus pushes expected
// products/tags, a negedge monitor pops and compares.
module tb_masked_mult_reduce_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1, zeroize = 1'b0, in_valid = 1'b0;
    logic [7:0]        in_tag = '0;
    logic [1:0][23:0]  u = '0, v = '0, x;
    logic [23:0]       rnd0_24bit = '0, rnd1_24bit = '0;
    logic              x_valid, red_valid, batch_done, busy;
    logic [7:0]        red_tag;

    masked_mult_reduce_feeder dut (
        .clk(clk), .rst(rst), .zeroize(zeroize), .in_valid(in_valid), .in_tag(in_tag),
        .u(u), .v(v), .rnd0_24bit(rnd0_24bit), .rnd1_24bit(rnd1_24bit),
        .x(x), .x_valid(x_valid), .red_valid(red_valid), .red_tag(red_tag),
        .batch_done(batch_done), .busy(busy)
    );

    typedef struct { int unsigned due; logic [23:0] sum; logic [23:0] x0; } xexp_t;
    typedef struct { int unsigned due; logic [7:0] tag; logic bd; } rexp_t;

    xexp_t xq[$];
    rexp_t rq[$];
    int unsigned cyc = 0;
    int n_cmp = 0, n_bad = 0;
    int model_count = 0;
    logic [23:0] mon_sum;
    logic        exp_busy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard heads every cycle.
    always @(negedge clk) begin
        while (xq.size() > 0 && xq[0].due < cyc) begin
            chk("x_lost", 64'(xq[0].due), 64'(cyc));
            void'(xq.pop_front());
        end
        while (rq.size() > 0 && rq[0].due < cyc) begin
            chk("red_lost", 64'(rq[0].due), 64'(cyc));
            void'(rq.pop_front());
        end
        exp_busy = (rq.size() > 0) && (rq[0].due <= cyc + 7);
        chk("busy", 64'(busy), 64'(exp_busy));
        if (xq.size() > 0 && xq[0].due == cyc) begin
            mon_sum = x[0] + x[1];
            chk("x_valid", 64'(x_valid), 64'd1);
            chk("x_sum", 64'(mon_sum), 64'(xq[0].sum));
            chk("x0_share", 64'(x[0]), 64'(xq[0].x0));
            void'(xq.pop_front());
        end else begin
            chk("x_valid_idle", 64'(x_valid), 64'd0);
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("red_valid", 64'(red_valid), 64'd1);
            chk("red_tag", 64'(red_tag), 64'(rq[0].tag));
            chk("batch_done", 64'(batch_done), 64'(rq[0].bd));
            $display("red result cyc=%0d tag=%0d batch_done=%0b", cyc, red_tag, batch_done);
            void'(rq.pop_front());
        end else begin
            chk("red_valid_idle", 64'({red_valid, red_tag, batch_done}), 64'd0);
        end
    end

    // One clock of stimulus with explicit shares. Expectations are derived from
    // the true operand values (share sums) and the share-0 blinding rule.
    task automatic step(input logic vld, input logic [7:0] tag,
                        input logic [23:0] u0, input logic [23:0] u1,
                        input logic [23:0] v0, input logic [23:0] v1,
                        input logic [23:0] r0, input logic [23:0] r1,
                        input logic zz, input logic rr);
        xexp_t xe;
        rexp_t re;
        logic [23:0] uv, vv;
        in_valid = vld; in_tag = tag;
        u[0] = u0; u[1] = u1; v[0] = v0; v[1] = v1;
        rnd0_24bit = r0; rnd1_24bit = r1;
        zeroize = zz; rst = rr;
        if (vld && !zz && !rr) begin
            uv = u0 + u1;
            vv = v0 + v1;
            xe.due = cyc + 2;
            xe.sum = uv * vv;
            xe.x0  = u0 * v0 + u0 * v1 + r0 - r1;
            xq.push_back(xe);
            re.due = cyc + 8;
            re.tag = tag;
            re.bd  = (model_count == 255);
            model_count = (model_count + 1) % 256;
            rq.push_back(re);
            $display("issue cyc=%0d tag=%0d u=%0d v=%0d", cyc, tag, uv, vv);
        end
        @(posedge clk);
        #1;
        if (zz || rr) begin
            xq.delete();
            rq.delete();
            model_count = 0;
        end
        in_valid = 1'b0; zeroize = 1'b0; rst = 1'b0;
    endtask

    // One clock with random shares of the given true values and random masks.
    task automatic issue(input logic vld, input logic [7:0] tag,
                         input logic [23:0] uval, input logic [23:0] vval,
                         input logic zz, input logic rr);
        logic [23:0] u0, v0;
        u0 = 24'($urandom);
        v0 = 24'($urandom);
        step(vld, tag, u0, uval - u0, v0, vval - v0,
             24'($urandom), 24'($urandom), zz, rr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 8'($urandom), 24'($urandom), 24'($urandom), 1'b0, 1'b0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, 64'({x, x_valid, red_valid, red_tag, batch_done, busy}), 64'd0);
    endtask

    logic [23:0] fixed_u0, fixed_v0;

    initial begin
        @(posedge clk); #1;
        issue(1'b0, 8'd0, 24'd0, 24'd0, 1'b0, 1'b1);
        issue(1'b0, 8'd0, 24'd0, 24'd0, 1'b0, 1'b1);
        chk_outputs_zero("reset_state");

        // Small product with hand-picked shares: 5 * 7 = 35.
        step(1'b1, 8'd1, 24'h000003, 24'h000002, 24'h000010, 24'hFFFFF7,
             24'h123456, 24'hABCDEF, 1'b0, 1'b0);
        idle(1);
        chk("x0_not_unmasked", 64'(x[0] == 24'd30), 64'd0);
        chk("x1_not_unmasked", 64'(x[1] == 24'd30), 64'd0);
        idle(8);

        // Largest operands, 3328*3328 = 0xA90000.
        step(1'b1, 8'd2, 24'h800000, 24'h800D00, 24'h800000, 24'h800D00,
             24'($urandom), 24'($urandom), 1'b0, 1'b0);
        idle(9);

        // Randomness extremes with identical operand shares.
        fixed_u0 = 24'($urandom);
        fixed_v0 = 24'($urandom);
        step(1'b1, 8'd3, fixed_u0, 24'd1234 - fixed_u0, fixed_v0, 24'd2999 - fixed_v0,
             24'h000000, 24'h000000, 1'b0, 1'b0);
        step(1'b1, 8'd4, fixed_u0, 24'd1234 - fixed_u0, fixed_v0, 24'd2999 - fixed_v0,
             24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0);
        idle(9);

        // Bubble pattern 1,0,1,1,0.
        issue(1'b1, 8'd10, 24'($urandom_range(3328)), 24'($urandom_range(3328)), 1'b0, 1'b0);
        issue(1'b0, 8'd11, 24'($urandom_range(3328)), 24'($urandom_range(3328)), 1'b0, 1'b0);
        issue(1'b1, 8'd12, 24'($urandom_range(3328)), 24'($urandom_range(3328)), 1'b0, 1'b0);
        issue(1'b1, 8'd13, 24'($urandom_range(3328)), 24'($urandom_range(3328)), 1'b0, 1'b0);
        issue(1'b0, 8'd14, 24'($urandom_range(3328)), 24'($urandom_range(3328)), 1'b0, 1'b0);
        idle(10);

        // Full batch from a cleared counter: tags 0..255, batch_done on 255.
        issue(1'b0, 8'd0, 24'd0, 24'd0, 1'b1, 1'b0);
        for (int i = 0; i < 256; i++)
            issue(1'b1, 8'(i), 24'($urandom_range(3328)), 24'($urandom_range(3328)), 1'b0, 1'b0);
        idle(10);

        // Three in flight, then zeroize: nothing emerges, busy drops.
        for (int i = 0; i < 3; i++)
            issue(1'b1, 8'(20 + i), 24'($urandom_range(3328)), 24'($urandom_range(3328)), 1'b0, 1'b0);
        issue(1'b0, 8'd0, 24'd0, 24'd0, 1'b1, 1'b0);
        chk("busy_after_zeroize", 64'(busy), 64'd0);
        issue(1'b1, 8'd30, 24'd100, 24'd200, 1'b0, 1'b0);
        idle(10);

        // rst together with in_valid: input dropped, outputs cleared.
        issue(1'b1, 8'd40, 24'd55, 24'd66, 1'b0, 1'b1);
        chk_outputs_zero("rst_with_valid");
        idle(12);

        // Random traffic with occasional zeroize.
        for (int i = 0; i < 400; i++)
            issue(1'($urandom_range(9) < 7), 8'($urandom),
                  24'($urandom_range(3328)), 24'($urandom_range(3328)),
                  1'($urandom_range(99) == 0), 1'b0);
        idle(12);

        chk("drain_x_queue", 64'(xq.size()), 64'd0);
        chk("drain_red_queue", 64'(rq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/masked_mult_reduce_feeder.md
Name: masked_mult_reduce_feeder

Overview:
- Upstream feeder for the masked Barrett reduction stage in the masked ML-KEM pointwise-multiply path.
- Takes two operands u and v, each held as 24-bit arithmetic shares modulo 2^24 with true values < MLKEM_Q. Produces the masked product x = u*v in 24-bit shares, blinding the cross terms with fresh randomness.
- Carries valid/tag sideband through its own latency plus the fixed 6-cycle reduction latency, so reduced results can be consumed with matching tags.
- Counts emerged results and pulses at each batch boundary.

Parameters:
- MASKED_REG_SIZE, 2*MLKEM_Q_WIDTH (24), share width.
- TAG_W, 8, sideband tag width (coefficient index).
- RED_LATENCY, 6, latency of the downstream reduction stage in cycles.
- BATCH, 256, results per batch_done pulse.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- zeroize  in  1  synchronous clear, same effect as rst.
- in_valid  in  1  operand pair present this cycle.
- in_tag  in  TAG_W  tag of operand pair.
- u  in  [1:0][MASKED_REG_SIZE-1:0]  operand u shares.
- v  in  [1:0][MASKED_REG_SIZE-1:0]  operand v shares.
- rnd0_24bit  in  MASKED_REG_SIZE  fresh randomness for cross term u0*v1.
- rnd1_24bit  in  MASKED_REG_SIZE  fresh randomness for cross term u1*v0.
- x  out  [1:0][MASKED_REG_SIZE-1:0]  masked product shares to the reduction stage.
- x_valid  out  1  x holds a product.
- red_valid  out  1  reduction-stage output y corresponds to a product this cycle.
- red_tag  out  TAG_W  tag aligned with red_valid.
- batch_done  out  1  single-cycle pulse on the BATCH-th red_valid of a batch.
- busy  out  1  any valid in flight.

Behaviour:
- Interface: one clock domain, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0 after rst or zeroize. This includes x, x_valid, red_valid, red_tag, batch_done, busy, all pipeline registers and the batch counter.
- Arithmetic: all mod 2^24, with every product truncated to 24 bits.
  - Stage 1 registers p00=u0*v0, p11=u1*v1, c01=u0*v1+rnd0, c10=u1*v0+rnd1.
  - Unblinded cross terms must never be registered.
  - Stage 2 registers x0 = p00 + c01 - rnd1_d and x1 = p11 + c10 - rnd0_d, where rnd*_d are the stage-1 randomness delayed one cycle.
  - Invariant: x0+x1 mod 2^24 == u*v, which is < 2^24 for u,v < 3329.
- Latency:
  - x and x_valid appear 2 cycles after in_valid.
  - red_valid and red_tag appear 2+RED_LATENCY = 8 cycles after in_valid.
  - Throughput is 1 per cycle; there is no backpressure, and the pipeline is free-running.
- Sideband: a valid shift register and a tag shift register, depth 2+RED_LATENCY. When in_valid=0 the tag stage holds don't-care, but red_tag must be 0 whenever red_valid=0.
- x shares: update every cycle regardless of valid. When x_valid=0 they carry garbage-but-masked data.
- batch counter, 0..BATCH-1:
  - Increments on red_valid.
  - On red_valid with count==BATCH-1, batch_done=1 that same cycle and the counter wraps to 0.
- busy: OR of all valid-pipeline bits. It is combinational from registers and carries no in_valid term.
- Simultaneous events:
  - rst or zeroize asserted together with in_valid: the input is dropped and everything clears.
  - zeroize mid-operation: all in-flight entries are discarded and no red_valid emerges for them. Counter returns to 0.
  - After zeroize deasserts, new inputs proceed with normal latency.

Decomposition:
- abr_params_pkg: MLKEM_Q, MLKEM_Q_WIDTH.
- ntt_defines_pkg: MASKED_MULT_LATENCY=2 and MASKED_BARRETT_LATENCY=6 constants.
- One sub-module, masked_share_mult_core: the 2-stage share-product/blinding datapath, with no sideband logic.
- The feeder wraps the core with the valid/tag delay line, batch counter and busy logic.

Test Plan:
- u shares (0x000003,0x000002), v shares (0x000010,0xFFFFF7), rnd0=0x123456, rnd1=0xABCDEF:
  - expect x_valid=1 at cycle+2 with x0+x1 mod 2^24 = 35.
  - Neither share equals the unmasked p00+p11 combination.
- u=v=3328, split (0x800000,0x800D00) each, rnd random:
  - expect x0+x1 mod 2^24 = 0xA90000 (11075584).
  - red_valid and red_tag at cycle+8.
- 256 back-to-back in_valid with tags 0..255, random shares and rnd:
  - red_tag sequence is 0..255 with red_valid continuous.
  - batch_done pulses only with tag 255; counter back at 0.
- Randomness extremes, rnd0=rnd1=0 then 0xFFFFFF with identical operands: same x0+x1 sum both times.
- Three valids in flight, zeroize for 1 cycle at cycle+3:
  - no red_valid for them; busy=0 the cycle after.
  - A subsequent input emerges 8 cycles later with batch count 1.
- rst asserted with in_valid=1: all outputs 0 next cycle and no result ever emerges.
- Bubble pattern 1,0,1,1,0: red_valid reproduces the pattern exactly, delayed 8 cycles.
